// File: rtl/ram_pkg.sv
// Shared types and helpers for the wait-state RAM controller.
// The optional per-byte parity is enabled with the RAM_PARITY_EN macro.
package ram_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } ram_state_e;

  // Number of byte lanes in a word of the given width
  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

  // Ceiling log2 for elaboration-time sizing (values up to 2^31)
  function automatic int clog2_int(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Even parity bit: data plus parity holds an even number of ones
  function automatic logic even_parity(input logic [7:0] data_byte);
    return ^data_byte;
  endfunction

endpackage

// File: rtl/ram_byte_bank.sv
// One byte lane of the RAM: synchronous write, registered read.
// With RAM_PARITY_EN defined each entry carries an even-parity bit and the
// lane reports a mismatch on its registered read data.
module ram_byte_bank
  import ram_pkg::*;
#(
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_BITS-1:0] i_addr,
  input  logic [7:0]            i_wdata,
`ifdef RAM_PARITY_EN
  output logic                  o_perr,
`endif
  output logic [7:0]            o_rdata
);

  localparam int DEPTH = 1 << DEPTH_BITS;

`ifdef RAM_PARITY_EN
  logic [8:0] r_mem [DEPTH];
  logic       r_rpar;

  // Lane write: data byte together with its freshly computed parity
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= {even_parity(i_wdata), i_wdata};
  end

  // Registered read of data and stored parity; cleared by reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_rdata <= 8'h00;
      r_rpar  <= 1'b0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr][7:0];
      r_rpar  <= r_mem[i_addr][8];
    end
  end

  assign o_perr = r_rpar ^ even_parity(o_rdata);
`else
  logic [7:0] r_mem [DEPTH];

  // Lane write
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Registered read; holds until the next read, cleared by reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_rdata <= 8'h00;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end
`endif

endmodule

// File: rtl/ram_wait_ctrl.sv
// Parametrised on-chip RAM with programmable wait states and a one-cycle
// ready pulse for the picorv32 native memory bus.
// Handshake: the master raises sel with address/wstrb/wdata stable and holds
// it until ready; ready is a single-cycle pulse in DONE, after which the
// controller spends one cycle back in IDLE before sampling sel again.
// Dropping sel during WAIT aborts the request with no write and no ready.
// Optional feature: RAM_PARITY_EN adds per-byte parity and drives err.
module ram_wait_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             sel,
  input  logic [lanes_of(DATA_WIDTH)-1:0]  wstrb,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             ready,
  output logic                             err
);

  localparam int LANES     = lanes_of(DATA_WIDTH);
  localparam int LANE_BITS = clog2_int(LANES);
  localparam int WORD_BITS = ADDR_WIDTH - LANE_BITS;
  localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam ram_state_e FIRST_STATE = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;

  ram_state_e             r_state;
  logic [3:0]             r_wait_cnt;
  logic [WORD_BITS-1:0]   r_word;
  logic [LANES-1:0]       r_wstrb;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic                   r_is_read;
  logic [LANES-1:0]       w_we;
  logic                   w_re;
  logic                   w_unused_addr;

  // Byte offset bits are ignored; the CPU handles sub-word alignment
  assign w_unused_addr = ^address;

  // Control FSM and wait counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wait_cnt <= 4'd0;
          if (sel) r_state <= FIRST_STATE;
        end
        ST_WAIT: begin
          if (!sel) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt == LAST_WAIT) begin
            r_state    <= ST_ACCESS;
            r_wait_cnt <= 4'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        ST_ACCESS: r_state <= ST_DONE;
        ST_DONE:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Request capture when a new transaction is accepted in IDLE
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && sel) begin
      r_word    <= address[ADDR_WIDTH-1:LANE_BITS];
      r_wstrb   <= wstrb;
      r_wdata   <= wdata;
      r_is_read <= (wstrb == '0);
    end
  end

  // Array strobes; resetn gating keeps a reset edge from committing a write
  always_comb begin
    w_re = (r_state == ST_ACCESS) && r_is_read;
    w_we = '0;
    if (r_state == ST_ACCESS && resetn) w_we = r_wstrb;
  end

  assign ready = (r_state == ST_DONE);

`ifdef RAM_PARITY_EN
  logic [LANES-1:0] w_perr;
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    ram_byte_bank #(
      .DEPTH_BITS (WORD_BITS)
    ) u_bank (
      .clk     (clk),
      .resetn  (resetn),
      .i_we    (w_we[gi]),
      .i_re    (w_re),
      .i_addr  (r_word),
      .i_wdata (r_wdata[8*gi +: 8]),
`ifdef RAM_PARITY_EN
      .o_perr  (w_perr[gi]),
`endif
      .o_rdata (rdata[8*gi +: 8])
    );
  end

`ifdef RAM_PARITY_EN
  // Parity error is reported only alongside read completion
  assign err = ready && r_is_read && (|w_perr);
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/ram_wait_ctrl.md
Name: ram_wait_ctrl

Overview:
- Parametrised on-chip RAM for the picorv32 SoC on the Tang Nano 20K. It is the successor of the fixed 2 KB, zero-latency RAM.
- Sits on the CPU native memory bus behind the address decoder. The decoder drives `sel` when the address hits the RAM window.
- Adds the following over the previous RAM:
  - configurable width and depth;
  - registered reads with a `ready` handshake;
  - programmable wait states;
  - arbitrary byte-strobe writes;
  - optional per-byte parity.

Parameters:
- ADDR_WIDTH, 12, byte-address bits decoded; depth = 2^(ADDR_WIDTH-LANE_BITS) words.
- DATA_WIDTH, 32, word width; must be 8·2^k, 8 ≤ DATA_WIDTH ≤ 64.
- WAIT_STATES, 0, extra cycles inserted before the access; range 0..15.
- Derived, not overridable: LANES = DATA_WIDTH/8, LANE_BITS = log2(LANES).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- sel  in  1  request valid (mem_valid & decode); held high by the master until ready.
- wstrb  in  LANES  byte write enables; all-zero means read.
- address  in  ADDR_WIDTH  byte address; the low LANE_BITS bits are ignored.
- wdata  in  DATA_WIDTH  write data, lane-aligned.
- rdata  out  DATA_WIDTH  registered full-word read data.
- ready  out  1  one-cycle completion pulse.
- err  out  1  parity error, qualified by ready; constant 0 when parity is compiled out.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE, wait counter=0, ready=0, rdata=0, err=0.
  - Memory contents are not cleared.
  - Reset has priority: a write scheduled on the same edge is not committed.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - sel=1: latch address, wstrb and wdata. Go to WAIT if WAIT_STATES>0, else ACCESS.
  - sel=0: stay in IDLE.
- WAIT:
  - Counter increments each cycle; go to ACCESS when count == WAIT_STATES-1.
  - If sel drops: abort to IDLE with no write and no ready.
- ACCESS (one cycle):
  - Write: each lane i with wstrb[i]=1 takes wdata[8i+7:8i]; other lanes keep their value. All 2^LANES strobe patterns are legal.
  - Read: rdata ← mem[word].
  - ready=1 in the following cycle (DONE). rdata is valid in that same cycle.
  - On a write, rdata is left unchanged.
  - If sel drops in ACCESS, the access still completes. The master is contractually not allowed to do this.
- DONE (one cycle):
  - ready=1, then back to IDLE unconditionally.
  - sel is ignored in DONE so that the master has one cycle to deassert. A new request is sampled in IDLE.
- Latency: sel sampled in IDLE at edge N → ready high during cycle N+WAIT_STATES+2 (ACCESS, then DONE). Throughput is one transaction per WAIT_STATES+3 cycles.
- Outputs:
  - ready is 0 in every state except DONE.
  - rdata holds its last value until the next read.
- No out-of-range case exists: the address width defines the depth exactly, and the decoder filters addresses above the window.
- Address misalignment is ignored; there is no shifting of read data. The CPU handles sub-word alignment.
- Reset mid-transaction (any state): return to IDLE next cycle, no ready pulse, no partial write.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Enabled:
  - Each lane stores an extra even-parity bit, computed from the written byte on every lane write.
  - On a read, err=1 in DONE if any lane's stored parity does not match its stored data. err is otherwise 0.
  - Writes always return err=0.
- Disabled:
  - No parity storage is built and err is tied to 0.
  - Port list is identical in both builds.

Decomposition:
- Package ram_pkg holds:
  - the state enum (IDLE/WAIT/ACCESS/DONE);
  - the lane-count and log2 helper functions;
  - the parity helper function.
- Sub-module ram_byte_bank: one 8-bit (+ optional parity bit) lane, depth 2^(ADDR_WIDTH-LANE_BITS), with a synchronous write-enable and a registered read.
  - The top instantiates LANES banks in a generate loop and contains only the FSM and the wait counter.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with sel=1 → ready=0, rdata=0, err=0 throughout; no memory change at 0x010.
- Write/read, WAIT_STATES=0: write 0xDEADBEEF, wstrb=1111, to 0x010; read 0x010 → ready 2 cycles after sel each time; rdata=0xDEADBEEF.
- Partial strobes: over 0xDEADBEEF, write wstrb=0101 with wdata=0x11223344 → read 0xDE22BE44. Then write wstrb=1000 with 0xAA000000 → read 0xAA22BE44.
- Wait states, WAIT_STATES=3: read → ready in exactly the 5th cycle after sel is sampled. Drop sel in the 2nd WAIT cycle → no ready, and a following read still returns the correct data.
- Back-to-back and wrap, ADDR_WIDTH=12: write 0x55 to the last word 0xFFC and 0x66 to 0x000; sel held continuously → ready pulses separated by ≥1 idle cycle; read 0xFFC=0x55, read 0x000=0x66.
- Parity (RAM_PARITY_EN): write 0x000000FF to 0x020, flip bit 0 of lane 0 via a hierarchical deposit, read → err=1 with ready. Rewrite the word and read again → err=0.
